// File: rtl/vector_ram_pkg.sv
// Shared types and address helpers for the banked vector RAM.
// Lane addresses are interleaved across banks: low bits pick the bank.
package vector_ram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP
  } state_t;

  function automatic int unsigned bank_of(
    input int unsigned a,
    input int unsigned n
  );
    return a % n;
  endfunction

  function automatic int unsigned row_of(
    input int unsigned a,
    input int unsigned n
  );
    return a / n;
  endfunction

endpackage

// File: rtl/vector_ram_banked_if.sv
// Request/response bundle of the banked vector RAM.
// The master issues lane requests; the slave returns read data.
interface vector_ram_banked_if #(
  parameter int PARALLELISM = 4,
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 32
);
  logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] addr;
  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] wdata;
  logic [PARALLELISM-1:0]                 lane_mask;
  logic                                   write;
  logic                                   valid;
  logic                                   ready;
  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] rdata;
  logic                                   rvalid;
  logic                                   rready;

  modport master (
    output addr, wdata, lane_mask, write,
    output valid, rready,
    input  ready, rdata, rvalid
  );

  modport slave (
    input  addr, wdata, lane_mask, write,
    input  valid, rready,
    output ready, rdata, rvalid
  );
endinterface

// File: rtl/vector_ram_bank.sv
// Single-port RAM bank with a registered one-cycle read.
// Contents are never reset.
module vector_ram_bank #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ROW_W      = 4
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ROW_W-1:0]      row,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[row] <= wdata;
      else    rdata    <= mem[row];
    end
  end
endmodule

// File: rtl/vector_ram_banked.sv
// Multi-lane RAM split into interleaved banks; conflicting lanes are
// serialised over rounds. Define VECTOR_RAM_STATS_EN for conflict_rounds.
module vector_ram_banked
  import vector_ram_pkg::*;
#(
  parameter int NUMBER_OF_RAMS = 4,
  parameter int VECTOR_LENGTH  = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int PARALLELISM    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef VECTOR_RAM_STATS_EN
  output logic [31:0] conflict_rounds,
`endif
  vector_ram_banked_if.slave bus
);
  localparam int N          = NUMBER_OF_RAMS;
  localparam int P          = PARALLELISM;
  localparam int ADDR_WIDTH = $clog2(VECTOR_LENGTH);
  localparam int BANK_DEPTH = (VECTOR_LENGTH + N - 1) / N;
  localparam int ROW_W      = BANK_DEPTH > 1 ? $clog2(BANK_DEPTH) : 1;

  state_t state, state_nx;

  logic [P-1:0][ADDR_WIDTH-1:0] addr_q;
  logic [P-1:0][DATA_WIDTH-1:0] wdata_q;
  logic [P-1:0][DATA_WIDTH-1:0] result_q;
  logic                         write_q;
  logic [P-1:0]                 pending_q;
  logic [P-1:0]                 cap_q;
  logic [P-1:0]                 grant;
  logic [P-1:0]                 inr;
  logic                         accept;
  logic                         issue_done;

  logic [N-1:0]                 busy;
  logic [N-1:0]                 bank_en;
  logic [N-1:0]                 bank_we;
  logic [N-1:0][ROW_W-1:0]      bank_row;
  logic [N-1:0][DATA_WIDTH-1:0] bank_wd;
  logic [N-1:0][DATA_WIDTH-1:0] bank_rd;

  assign accept = (state == IDLE) && bus.valid;

  always_comb begin
    inr = '0;
    for (int l = 0; l < P; l++)
      inr[l] = int'(addr_q[l]) < VECTOR_LENGTH;
  end

  // Out-of-range lanes still win a bank slot but never touch the RAM.
  always_comb begin
    grant    = '0;
    busy     = '0;
    bank_en  = '0;
    bank_we  = '0;
    bank_row = '0;
    bank_wd  = '0;
    if (state == ISSUE) begin
      for (int b = 0; b < N; b++) begin
        for (int l = 0; l < P; l++) begin
          if (!busy[b] && pending_q[l] &&
              bank_of(32'(addr_q[l]), N) == 32'(b)) begin
            busy[b]  = 1'b1;
            grant[l] = 1'b1;
            if (inr[l]) begin
              bank_en[b]  = 1'b1;
              bank_we[b]  = write_q;
              bank_row[b] = ROW_W'(row_of(32'(addr_q[l]), N));
              bank_wd[b]  = wdata_q[l];
            end
          end
        end
      end
    end
  end

  assign issue_done = (pending_q & ~grant) == '0;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (bus.valid) state_nx = ISSUE;
      ISSUE: if (issue_done) state_nx = write_q ? IDLE : DRAIN;
      DRAIN: state_nx = RESP;
      RESP:  if (bus.rready) state_nx = IDLE;
    endcase
  end

  assign bus.ready  = state == IDLE;
  assign bus.rvalid = state == RESP;
  assign bus.rdata  = (state == RESP) ? result_q : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending_q <= '0;
      cap_q     <= '0;
      result_q  <= '0;
    end else begin
      state <= state_nx;
      cap_q <= write_q ? '0 : (grant & inr);
      if (accept) begin
        pending_q <= bus.lane_mask;
        result_q  <= '0;
      end else begin
        pending_q <= pending_q & ~grant;
        // Bank output is valid the cycle after the lane was served.
        for (int l = 0; l < P; l++)
          for (int b = 0; b < N; b++)
            if (cap_q[l] && bank_of(32'(addr_q[l]), N) == 32'(b))
              result_q[l] <= bank_rd[b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= bus.addr;
      wdata_q <= bus.wdata;
      write_q <= bus.write;
    end
  end

`ifdef VECTOR_RAM_STATS_EN
  logic        first_q;
  logic [31:0] conflict_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_q    <= 1'b0;
      conflict_q <= '0;
    end else begin
      if (accept)              first_q <= 1'b1;
      else if (state == ISSUE) first_q <= 1'b0;
      if (state == ISSUE && !first_q && conflict_q != '1)
        conflict_q <= conflict_q + 32'd1;
    end
  end

  assign conflict_rounds = conflict_q;
`endif

  for (genvar b = 0; b < N; b++) begin : g_bank
    vector_ram_bank #(
      .DEPTH      (BANK_DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ROW_W      (ROW_W)
    ) u_bank (
      .clk   (clk),
      .en    (bank_en[b]),
      .we    (bank_we[b]),
      .row   (bank_row[b]),
      .wdata (bank_wd[b]),
      .rdata (bank_rd[b])
    );
  end
endmodule

// File: tb/tb_vector_ram_banked.sv
// Scoreboard bench for vector_ram_banked: directed cases plus random
// requests checked against an array model of the stored vector.
module tb_vector_ram_banked;
  localparam int N  = 2;
  localparam int P  = 4;
  localparam int VL = 32;
  localparam int D  = 32;
  localparam int A  = 5;

  typedef logic [P-1:0][A-1:0] addr_t;
  typedef logic [P-1:0][D-1:0] data_t;
  typedef struct {
    data_t data;
    int    cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_ram_banked_if #(
    .PARALLELISM (P),
    .ADDR_WIDTH  (A),
    .DATA_WIDTH  (D)
  ) bus ();

`ifdef VECTOR_RAM_STATS_EN
  logic [31:0] conflict_rounds;
`endif

  vector_ram_banked #(
    .NUMBER_OF_RAMS (N),
    .VECTOR_LENGTH  (VL),
    .DATA_WIDTH     (D),
    .PARALLELISM    (P)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef VECTOR_RAM_STATS_EN
    .conflict_rounds (conflict_rounds),
`endif
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [D-1:0] mem [VL];
  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int resp_done = 0;
  int stall = 0;
  bit in_resp = 0;
  bit chk_ready = 0;
  data_t held;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic addr_t mk_a(int a0, int a1, int a2, int a3);
    addr_t a;
    a[0] = A'(a0);
    a[1] = A'(a1);
    a[2] = A'(a2);
    a[3] = A'(a3);
    return a;
  endfunction

  // Rounds = busiest bank's lane count, at least one.
  function automatic int rounds(addr_t a, logic [P-1:0] m);
    int cnt [N];
    int r = 0;
    foreach (cnt[i]) cnt[i] = 0;
    for (int l = 0; l < P; l++)
      if (m[l]) cnt[int'(a[l]) % N]++;
    for (int b = 0; b < N; b++)
      if (cnt[b] > r) r = cnt[b];
    return (r == 0) ? 1 : r;
  endfunction

  always @(posedge clk) begin
    #1;
    if (stall > 0) begin
      stall--;
      bus.rready = 1'b0;
    end else begin
      bus.rready = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_ready) begin
        chk("ready_after_resp", 128'(bus.ready), 128'(1));
        chk("rvalid_after_resp", 128'(bus.rvalid), 128'(0));
        chk_ready = 0;
      end
      if (bus.rvalid) begin
        if (!in_resp) begin
          if (q.size() == 0) begin
            chk("rvalid_unexpected", 128'(bus.rvalid), 128'(0));
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("rdata", 128'(bus.rdata), 128'(e.data));
            chk("rvalid_cycle", 128'(cyc), 128'(e.cyc));
            held = bus.rdata;
            in_resp = 1;
          end
        end else begin
          chk("rdata_stable", 128'(bus.rdata), 128'(held));
        end
        chk("ready_in_resp", 128'(bus.ready), 128'(0));
        if (bus.rready && in_resp) begin
          in_resp = 0;
          chk_ready = 1;
          resp_done++;
        end
      end else begin
        chk("rdata_zero", 128'(bus.rdata), 128'(0));
      end
    end
  end

  // Caller sits just after a rising edge with the DUT idle.
  task automatic do_req(input bit wr, input addr_t a, input data_t d,
                        input logic [P-1:0] m);
    int r;
    int t;
    int n;
    data_t ex;
    r = rounds(a, m);
    ex = '0;
    for (int l = 0; l < P; l++)
      if (m[l] && int'(a[l]) < VL) ex[l] = mem[a[l]];
    chk("ready_idle", 128'(bus.ready), 128'(1));
    bus.addr = a;
    bus.wdata = d;
    bus.lane_mask = m;
    bus.write = wr;
    bus.valid = 1'b1;
    t = cyc;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    if (wr) begin
      for (int l = 0; l < P; l++)
        if (m[l] && int'(a[l]) < VL) mem[a[l]] = d[l];
      while (!bus.ready && cyc - t < 60) begin
        @(posedge clk);
        #1;
      end
      chk("write_ready_cycle", 128'(cyc), 128'(t + 1 + r));
    end else begin
      n = resp_done;
      q.push_back('{ex, t + 2 + r});
      while (resp_done == n && cyc - t < 200) begin
        @(posedge clk);
        #1;
      end
      chk("resp_timeout", 128'(resp_done), 128'(n + 1));
    end
  endtask

  initial begin
    addr_t a;
    data_t d;
    logic [P-1:0] m;
    bus.addr = '0;
    bus.wdata = '0;
    bus.lane_mask = '0;
    bus.write = 1'b0;
    bus.valid = 1'b0;
    bus.rready = 1'b0;
    foreach (mem[i]) mem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_ready", 128'(bus.ready), 128'(1));
    chk("reset_rvalid", 128'(bus.rvalid), 128'(0));
    chk("reset_rdata", 128'(bus.rdata), 128'(0));
`ifdef VECTOR_RAM_STATS_EN
    chk("stats_reset", 128'(conflict_rounds), 128'(0));
`endif

    d = '0;
    d[0] = 32'hA0; d[1] = 32'hB1; d[2] = 32'hC2; d[3] = 32'hD3;
    do_req(1, mk_a(0, 1, 2, 3), d, 4'b1111);
`ifdef VECTOR_RAM_STATS_EN
    chk("stats_two_rounds", 128'(conflict_rounds), 128'(1));
`endif

    for (int base = 4; base < VL; base += 4) begin
      for (int l = 0; l < P; l++) d[l] = $urandom;
      do_req(1, mk_a(base, base + 1, base + 2, base + 3), d, 4'b1111);
    end

    do_req(0, mk_a(0, 1, 2, 3), '0, 4'b1111);
    do_req(0, mk_a(6, 6, 6, 6), '0, 4'b1111);
    do_req(0, mk_a(4, 5, 6, 7), '0, 4'b0101);
    stall = 9;
    do_req(0, mk_a(0, 1, 2, 3), '0, 4'b1111);
    do_req(0, mk_a(9, 9, 9, 9), '0, 4'b0000);
    do_req(1, mk_a(9, 9, 9, 9), '0, 4'b0000);

    d = '0;
    d[0] = 32'd1; d[2] = 32'd2;
    do_req(1, mk_a(5, 0, 5, 0), d, 4'b0101);
    do_req(0, mk_a(5, 5, 5, 5), '0, 4'b1111);

    for (int i = 0; i < 80; i++) begin
      for (int l = 0; l < P; l++) begin
        a[l] = A'($urandom_range(0, VL - 1));
        d[l] = $urandom;
      end
      m = P'($urandom);
      do_req(($urandom % 2) == 1, a, d, m);
    end

    // Reset in the middle of a four-round read drops it.
    bus.addr = mk_a(6, 6, 6, 6);
    bus.lane_mask = 4'b1111;
    bus.write = 1'b0;
    bus.valid = 1'b1;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midreset_ready", 128'(bus.ready), 128'(1));
    chk("midreset_rvalid", 128'(bus.rvalid), 128'(0));
`ifdef VECTOR_RAM_STATS_EN
    chk("stats_midreset", 128'(conflict_rounds), 128'(0));
`endif
    do_req(0, mk_a(0, 1, 2, 3), '0, 4'b1111);
    do_req(0, mk_a(6, 6, 6, 6), '0, 4'b1111);

    repeat (3) @(posedge clk);
    chk("queue_empty", 128'(q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
